// File: rtl/serial_add_sequencer.sv
// Bit-serial 32-bit adder/subtractor: latches operands on start, adds one bit per
// cycle LSB-first, then pulses done with sum, carry_out and signed overflow.
module serial_add_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic        busy,
  output logic        done,
  output logic [31:0] sum,
  output logic        carry_out,
  output logic        overflow,
  output logic        bit_out,
  output logic        bit_valid
);

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [W-1:0]    opa;
  logic [W-1:0]    opb;
  logic            carry;
  logic [CW-1:0]   count;
  logic            s_c;
  logic            carry_next_c;

  // Full-adder slice on the current LSBs.
  assign s_c          = opa[0] ^ opb[0] ^ carry;
  assign carry_next_c = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);

  assign bit_valid = (state == RUN);
  assign bit_out   = bit_valid & s_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      opa       <= '0;
      opb       <= '0;
      carry     <= 1'b0;
      count     <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            // Subtract as A + ~B + 1, so carry_out is the no-borrow flag.
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub;
            count <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          carry <= carry_next_c;
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          sum   <= {s_c, sum[W-1:1]};
          count <= count + CW'(1);
          if (count == CW'(W - 1)) begin
            carry_out <= carry_next_c;
            overflow  <= carry ^ carry_next_c;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Scoreboard bench for serial_add_sequencer: directed operations push expected
// results; a negedge monitor checks every done pulse and the serial bit stream.
module tb_serial_add_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic        busy;
  logic        done;
  logic [31:0] sum;
  logic        carry_out;
  logic        overflow;
  logic        bit_out;
  logic        bit_valid;

  typedef struct {
    string       name;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  serial_add_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow),
    .bit_out   (bit_out),
    .bit_valid (bit_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Monitor: collects the serial stream and checks each done against the queue.
  logic [31:0] stream;
  int          nbits;
  initial begin
    stream = '0;
    nbits  = 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      nbits = 0;
    end else begin
      if (bit_valid) begin
        stream = {bit_out, stream[31:1]};
        nbits++;
      end else begin
        check("bit_out_idle", 32'(bit_out), 32'd0);
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_done: got done=1 expected no pending result (sum=0x%08h)", sum);
        end else begin
          e = exp_q.pop_front();
          check({e.name, "_sum"},    sum,              e.sum);
          check({e.name, "_cout"},   32'(carry_out),   32'(e.cout));
          check({e.name, "_ovf"},    32'(overflow),    32'(e.ovf));
          check({e.name, "_stream"}, stream,           e.sum);
          check({e.name, "_nbits"},  32'(nbits),       32'd32);
          check({e.name, "_busy"},   32'(busy),        32'd1);
        end
        nbits = 0;
      end
    end
  end

  // Issue one operation; operands are scrambled right after acceptance.
  task automatic launch(input string name, input logic [31:0] ta, input logic [31:0] tb_,
                        input logic tsub, input logic push,
                        input logic [31:0] esum, input logic ecout, input logic eovf);
    exp_t e;
    @(posedge clk);
    #1;
    check({name, "_ready"}, 32'(busy), 32'd0);
    a     = ta;
    b     = tb_;
    sub   = tsub;
    start = 1'b1;
    if (push) begin
      e.name = name;
      e.sum  = esum;
      e.cout = ecout;
      e.ovf  = eovf;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    sub   = 1'($urandom_range(0, 1));
  endtask

  // Count negedges until done, bounded.
  task automatic wait_done(input string name, input int exp_lat);
    int cycles;
    cycles = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    check({name, "_latency"}, 32'(cycles), 32'(exp_lat));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b1;
    a     = 32'hDEAD_BEEF;
    b     = 32'h1234_5678;
    sub   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    start = 1'b0;
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_sum",       sum,            32'd0);
    check("rst_cout",      32'(carry_out), 32'd0);
    check("rst_ovf",       32'(overflow),  32'd0);
    check("rst_bit_valid", 32'(bit_valid), 32'd0);
    check("rst_bit_out",   32'(bit_out),   32'd0);

    launch("add5_3", 32'd5, 32'd3, 1'b0, 1'b1, 32'h0000_0008, 1'b0, 1'b0);
    wait_done("add5_3", 33);
    repeat (3) @(negedge clk);
    check("hold_sum",  sum,         32'h0000_0008);
    check("hold_done", 32'(done),   32'd0);
    check("hold_busy", 32'(busy),   32'd0);

    // Back-to-back from here on: each launch starts in the first IDLE cycle.
    launch("wrap", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    wait_done("wrap", 33);
    launch("sovf", 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    wait_done("sovf", 33);
    launch("sub10_3", 32'd10, 32'd3, 1'b1, 1'b1, 32'd7, 1'b1, 1'b0);
    wait_done("sub10_3", 33);
    launch("sub3_10", 32'd3, 32'd10, 1'b1, 1'b1, 32'hFFFF_FFF9, 1'b0, 1'b0);
    wait_done("sub3_10", 33);

    // Start re-pulsed during RUN must be ignored.
    launch("ignore", 32'd100, 32'd23, 1'b0, 1'b1, 32'd123, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    a     = 32'hAAAA_0000;
    b     = 32'h0000_5555;
    sub   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("ignore", 27);
    repeat (40) @(negedge clk);

    // Leave carry_out=1 behind, then abort a run at count==10.
    launch("sub7_2", 32'd7, 32'd2, 1'b1, 1'b1, 32'd5, 1'b1, 1'b0);
    wait_done("sub7_2", 33);
    launch("abort", 32'h1234_5678, 32'd1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort_busy",      32'(busy),      32'd0);
    check("abort_done",      32'(done),      32'd0);
    check("abort_sum",       sum,            32'd0);
    check("abort_cout",      32'(carry_out), 32'd0);
    check("abort_bit_valid", 32'(bit_valid), 32'd0);
    repeat (40) @(negedge clk);

    launch("recover", 32'd1, 32'd1, 1'b0, 1'b1, 32'd2, 1'b0, 1'b0);
    wait_done("recover", 33);
    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
